// File: rtl/tbufcam_issue.sv
// -----------------------------------------------------------------------------
// tbufcam_issue
//
// Issue/retire side of the translation-miss tracking path. Miss addresses are
// parked in per-thread slots, handed one at a time to the page-walk requester
// over a valid/ack handshake, and released when a response with a matching
// tag returns. A per-slot generation bit, toggled on every allocation, makes
// responses that belong to an earlier occupant of a slot miss the tag match.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   except, except_thread flush every slot of one thread
//   new_en/addr/thread    enqueue a miss for a thread
//   full                  no FREE slot in thread new_thread (combinational)
//   pending[t]            thread t owns at least one non-FREE slot
//   req_en/addr/thread    registered request to the walker, held until ack
//   req_tag               {gen, thread, slot} of the request
//   req_ack               walker accepts when req_en & req_ack
//   rsp_en, rsp_tag       response from the walker (always accepted)
//   rsp_done/addr/thread  registered one-cycle completion pulse to fetch
// -----------------------------------------------------------------------------
module tbufcam_issue #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except,
  input  logic              except_thread,
  input  logic              new_en,
  input  logic [WIDTH-1:0]  new_addr,
  input  logic              new_thread,
  output logic              full,
  output logic [1:0]        pending,
  output logic              req_en,
  output logic [WIDTH-1:0]  req_addr,
  output logic              req_thread,
  output logic [IW+1:0]     req_tag,
  input  logic              req_ack,
  input  logic              rsp_en,
  input  logic [IW+1:0]     rsp_tag,
  output logic              rsp_done,
  output logic [WIDTH-1:0]  rsp_addr,
  output logic              rsp_thread
);

  localparam int NS = 2 * DEPTH;

  // Slot states
  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ISSUED = 2'd2;

  // Issue FSM states
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  // Slot index is {thread, slot}; thread 1 occupies the upper half.
  logic [NS-1:0]            is_free;
  logic [NS-1:0]            is_wait;
  logic [NS-1:0]            is_issued;
  logic [NS-1:0]            slot_gen;
  logic [NS-1:0][WIDTH-1:0] slot_addr;

  logic [DEPTH-1:0] free0, free1, wait0, wait1;
  assign free0 = is_free[DEPTH-1:0];
  assign free1 = is_free[NS-1:DEPTH];
  assign wait0 = is_wait[DEPTH-1:0];
  assign wait1 = is_wait[NS-1:DEPTH];

  logic fsm;
  logic rr;

  // Lowest set bit of a per-thread slot vector.
  function automatic logic [IW-1:0] lowest(input logic [DEPTH-1:0] v);
    logic [IW-1:0] idx;
    // NOTE: idx gets a value before the loop so every path assigns it; a
    // variable left unassigned on some path of combinational code infers a latch.
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v[k]) idx = IW'(k);
    end
    return idx;
  endfunction

  // Flush request decoded per thread.
  logic [1:0] flush_thr;
  assign flush_thr = {except & except_thread, except & ~except_thread};

  // Occupancy is taken from registered slot state only.
  assign full    = new_thread ? ~|free1 : ~|free0;
  assign pending = {~&free1, ~&free0};

  // Allocation: lowest FREE slot of the owning thread; a flush of that thread
  // in the same cycle wins and the miss is dropped.
  logic          alloc_ok;
  logic [IW-1:0] alloc_slot;
  logic [IW:0]   alloc_idx;
  assign alloc_slot = lowest(new_thread ? free1 : free0);
  assign alloc_idx  = {new_thread, alloc_slot};
  assign alloc_ok   = new_en & ~full & ~flush_thr[new_thread];

  // Issue pick: round-robin between threads only when both have work; a
  // thread being flushed this cycle is not offered, since its slots vanish.
  logic [1:0]    cand;
  logic          pick_valid;
  logic          pick_thread;
  logic [IW-1:0] pick_slot;
  logic [IW:0]   pick_idx;
  assign cand        = {(|wait1) & ~flush_thr[1], (|wait0) & ~flush_thr[0]};
  assign pick_valid  = |cand;
  assign pick_thread = (&cand) ? rr : cand[1];
  assign pick_slot   = lowest(pick_thread ? wait1 : wait0);
  assign pick_idx    = {pick_thread, pick_slot};

  // Handshake outcome while a request is outstanding; flush beats ack.
  logic withdraw;
  logic ack_ok;
  assign withdraw = (fsm == ST_REQ) & flush_thr[req_thread];
  assign ack_ok   = (fsm == ST_REQ) & req_en & req_ack & ~flush_thr[req_thread];

  // Retire: tag must address an ISSUED slot whose generation still matches.
  logic [IW:0] rsp_idx;
  logic        ret_ok;
  assign rsp_idx = rsp_tag[IW:0];
  assign ret_ok  = rsp_en & is_issued[rsp_idx] &
                   (slot_gen[rsp_idx] == rsp_tag[IW+1]) &
                   ~flush_thr[rsp_tag[IW]];

  // Per-slot storage. Allocation, ack and retire always target different
  // slots (FREE, WAIT and ISSUED respectively), so the chain below only
  // orders them against flush.
  for (genvar i = 0; i < NS; i++) begin : g_slot
    localparam logic [IW:0] IDX = (IW+1)'(i);

    logic [1:0]       st;
    logic             gen;
    logic [WIDTH-1:0] addr;

    always_ff @(posedge clk or posedge rst) begin
      // NOTE: the slot array is small and its state/gen bits decide whether a
      // response is accepted, so it is reset along with the control state.
      if (rst) begin
        st   <= S_FREE;
        gen  <= 1'b0;
        addr <= '0;
      end else if (flush_thr[IDX[IW]]) begin
        st <= S_FREE;
      end else if (alloc_ok && (alloc_idx == IDX)) begin
        st   <= S_WAIT;
        addr <= new_addr;
        gen  <= ~gen;
      end else if (ack_ok && (req_tag[IW:0] == IDX)) begin
        st <= S_ISSUED;
      end else if (ret_ok && (rsp_idx == IDX)) begin
        st <= S_FREE;
      end
    end

    assign is_free[i]   = (st == S_FREE);
    assign is_wait[i]   = (st == S_WAIT);
    assign is_issued[i] = (st == S_ISSUED);
    assign slot_gen[i]  = gen;
    assign slot_addr[i] = addr;
  end

  // Issue FSM and completion register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      fsm        <= ST_IDLE;
      rr         <= 1'b0;
      req_en     <= 1'b0;
      req_addr   <= '0;
      req_thread <= 1'b0;
      req_tag    <= '0;
      rsp_done   <= 1'b0;
      rsp_addr   <= '0;
      rsp_thread <= 1'b0;
    end else begin
      rsp_done <= ret_ok;
      if (ret_ok) begin
        rsp_addr   <= slot_addr[rsp_idx];
        rsp_thread <= rsp_tag[IW];
      end

      case (fsm)
        ST_IDLE: begin
          if (pick_valid) begin
            req_en     <= 1'b1;
            req_addr   <= slot_addr[pick_idx];
            req_thread <= pick_thread;
            req_tag    <= {slot_gen[pick_idx], pick_idx};
            fsm        <= ST_REQ;
          end
        end
        default: begin
          // req_* held stable until accepted or withdrawn by a flush.
          if (withdraw) begin
            req_en <= 1'b0;
            fsm    <= ST_IDLE;
          end else if (ack_ok) begin
            req_en <= 1'b0;
            rr     <= ~req_thread;
            fsm    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbufcam_issue.sv
// -----------------------------------------------------------------------------
// tb_tbufcam_issue
//
// Directed bench for tbufcam_issue (WIDTH=11, DEPTH=4, 4-bit tags). Inputs are
// driven and outputs sampled 1 ns after each rising edge; every expected value
// is written out by hand from the tag layout {gen, thread, slot}.
// -----------------------------------------------------------------------------
module tb_tbufcam_issue;

  logic        clk;
  logic        rst;
  logic        except;
  logic        except_thread;
  logic        new_en;
  logic [10:0] new_addr;
  logic        new_thread;
  logic        full;
  logic [1:0]  pending;
  logic        req_en;
  logic [10:0] req_addr;
  logic        req_thread;
  logic [3:0]  req_tag;
  logic        req_ack;
  logic        rsp_en;
  logic [3:0]  rsp_tag;
  logic        rsp_done;
  logic [10:0] rsp_addr;
  logic        rsp_thread;

  int checks = 0;
  int errors = 0;

  tbufcam_issue #(.WIDTH(11), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .except        (except),
    .except_thread (except_thread),
    .new_en        (new_en),
    .new_addr      (new_addr),
    .new_thread    (new_thread),
    .full          (full),
    .pending       (pending),
    .req_en        (req_en),
    .req_addr      (req_addr),
    .req_thread    (req_thread),
    .req_tag       (req_tag),
    .req_ack       (req_ack),
    .rsp_en        (rsp_en),
    .rsp_tag       (rsp_tag),
    .rsp_done      (rsp_done),
    .rsp_addr      (rsp_addr),
    .rsp_thread    (rsp_thread)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic thr, input logic [10:0] a);
    new_en     = 1'b1;
    new_thread = thr;
    new_addr   = a;
    step();
    new_en     = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, accept it, check it drops.
  task automatic ack_expect(input string name, input logic thr,
                            input logic [10:0] a, input logic [3:0] tag);
    int n;
    n = 0;
    while (req_en !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check({name, "_req_en"}, 32'(req_en), 32'd1);
    check({name, "_thread"}, 32'(req_thread), 32'(thr));
    check({name, "_addr"}, 32'(req_addr), 32'(a));
    check({name, "_tag"}, 32'(req_tag), 32'(tag));
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    check({name, "_drop"}, 32'(req_en), 32'd0);
  endtask

  task automatic rsp_expect(input string name, input logic [3:0] tag, input logic done,
                            input logic [10:0] a, input logic thr);
    rsp_en  = 1'b1;
    rsp_tag = tag;
    step();
    rsp_en  = 1'b0;
    check({name, "_done"}, 32'(rsp_done), 32'(done));
    if (done) begin
      check({name, "_addr"}, 32'(rsp_addr), 32'(a));
      check({name, "_thread"}, 32'(rsp_thread), 32'(thr));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_en"}, 32'(req_en), 32'd0);
    check({name, "_req_addr"}, 32'(req_addr), 32'd0);
    check({name, "_req_thread"}, 32'(req_thread), 32'd0);
    check({name, "_req_tag"}, 32'(req_tag), 32'd0);
    check({name, "_rsp_done"}, 32'(rsp_done), 32'd0);
    check({name, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
    check({name, "_rsp_thread"}, 32'(rsp_thread), 32'd0);
    check({name, "_pending"}, 32'(pending), 32'd0);
    check({name, "_full"}, 32'(full), 32'd0);
  endtask

  initial begin
    rst = 1'b1; except = 1'b0; except_thread = 1'b0;
    new_en = 1'b0; new_addr = '0; new_thread = 1'b0;
    req_ack = 1'b0; rsp_en = 1'b0; rsp_tag = '0;
    #1;
    check_reset_outputs("reset");
    #1 rst = 1'b0;
    step();

    // Single miss: enqueue at cycle 1, request at cycle 3, response at 6.
    new_en = 1'b1; new_addr = 11'h155; new_thread = 1'b0;
    step();                                             // cycle 2
    new_en = 1'b0;
    check("c2_req_en", 32'(req_en), 32'd0);
    check("c2_pending", 32'(pending), 32'b01);
    step();                                             // cycle 3
    check("c3_req_en", 32'(req_en), 32'd1);
    check("c3_req_tag", 32'(req_tag), 32'b1000);
    check("c3_req_addr", 32'(req_addr), 32'h155);
    check("c3_req_thread", 32'(req_thread), 32'd0);
    req_ack = 1'b1;
    step();                                             // cycle 4
    req_ack = 1'b0;
    check("c4_req_en", 32'(req_en), 32'd0);
    check("c4_pending", 32'(pending), 32'b01);
    step();                                             // cycle 5
    step();                                             // cycle 6
    rsp_en = 1'b1; rsp_tag = 4'b1000;
    step();                                             // cycle 7
    rsp_en = 1'b0;
    check("c7_rsp_done", 32'(rsp_done), 32'd1);
    check("c7_rsp_addr", 32'(rsp_addr), 32'h155);
    check("c7_rsp_thread", 32'(rsp_thread), 32'd0);
    check("c7_pending", 32'(pending), 32'd0);
    step();                                             // cycle 8
    check("c8_rsp_done", 32'(rsp_done), 32'd0);

    // Fill thread 1; a fifth miss is dropped.
    alloc(1'b1, 11'h201);
    alloc(1'b1, 11'h202);
    alloc(1'b1, 11'h203);
    alloc(1'b1, 11'h204);
    new_thread = 1'b1;
    #1;
    check("full_t1", 32'(full), 32'd1);
    check("full_pending", 32'(pending), 32'b10);
    alloc(1'b1, 11'h2FF);
    new_thread = 1'b0;
    #1;
    check("full_t0", 32'(full), 32'd0);
    ack_expect("t1s0", 1'b1, 11'h201, 4'b1100);
    ack_expect("t1s1", 1'b1, 11'h202, 4'b1101);
    ack_expect("t1s2", 1'b1, 11'h203, 4'b1110);
    ack_expect("t1s3", 1'b1, 11'h204, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_fifth_req", 32'(req_en), 32'd0);
    end
    rsp_expect("t1r0", 4'b1100, 1'b1, 11'h201, 1'b1);
    rsp_expect("t1r1", 4'b1101, 1'b1, 11'h202, 1'b1);
    rsp_expect("t1r2", 4'b1110, 1'b1, 11'h203, 1'b1);
    rsp_expect("t1r3", 4'b1111, 1'b1, 11'h204, 1'b1);
    check("t1_pending", 32'(pending), 32'd0);

    // Two WAIT slots per thread: issue order alternates 0,1,0,1.
    alloc(1'b0, 11'h011);
    alloc(1'b1, 11'h022);
    alloc(1'b0, 11'h033);
    alloc(1'b1, 11'h044);
    ack_expect("rr0", 1'b0, 11'h011, 4'b0000);
    ack_expect("rr1", 1'b1, 11'h022, 4'b0100);
    ack_expect("rr2", 1'b0, 11'h033, 4'b1001);
    ack_expect("rr3", 1'b1, 11'h044, 4'b0101);
    rsp_expect("rrr0", 4'b0000, 1'b1, 11'h011, 1'b0);
    rsp_expect("rrr1", 4'b0100, 1'b1, 11'h022, 1'b1);
    rsp_expect("rrr2", 4'b1001, 1'b1, 11'h033, 1'b0);
    rsp_expect("rrr3", 4'b0101, 1'b1, 11'h044, 1'b1);
    check("rr_pending", 32'(pending), 32'd0);

    // Flush thread 0 in the same cycle as its ack; thread 1 unaffected.
    alloc(1'b0, 11'h0AA);
    alloc(1'b1, 11'h0BB);
    check("fl_req_en", 32'(req_en), 32'd1);
    check("fl_req_thread", 32'(req_thread), 32'd0);
    check("fl_req_tag", 32'(req_tag), 32'b1000);
    except = 1'b1; except_thread = 1'b0; req_ack = 1'b1;
    step();
    except = 1'b0; req_ack = 1'b0;
    check("fl_req_drop", 32'(req_en), 32'd0);
    check("fl_pending", 32'(pending), 32'b10);
    ack_expect("fl_t1", 1'b1, 11'h0BB, 4'b1100);
    rsp_expect("fl_old_tag", 4'b1000, 1'b0, 11'h000, 1'b0);
    rsp_expect("fl_t1_ret", 4'b1100, 1'b1, 11'h0BB, 1'b1);
    check("fl_pending_end", 32'(pending), 32'd0);

    // Flush beats allocation on the same thread.
    except = 1'b1; except_thread = 1'b0;
    alloc(1'b0, 11'h0EE);
    except = 1'b0;
    check("fa_pending", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fa_no_req", 32'(req_en), 32'd0);
    end

    // Re-allocated slot 0 of thread 0 now carries gen 0; gen 1 is stale.
    alloc(1'b0, 11'h0DD);
    ack_expect("regen", 1'b0, 11'h0DD, 4'b0000);
    rsp_expect("stale_gen", 4'b1000, 1'b0, 11'h000, 1'b0);
    check("stale_pending", 32'(pending), 32'b01);
    rsp_expect("fresh_gen", 4'b0000, 1'b1, 11'h0DD, 1'b0);
    check("fresh_pending", 32'(pending), 32'd0);

    // Reset with three slots ISSUED and a fourth request outstanding.
    alloc(1'b0, 11'h101);
    alloc(1'b0, 11'h102);
    alloc(1'b0, 11'h103);
    alloc(1'b0, 11'h104);
    ack_expect("pr0", 1'b0, 11'h101, 4'b1000);
    ack_expect("pr1", 1'b0, 11'h102, 4'b0001);
    ack_expect("pr2", 1'b0, 11'h103, 4'b1010);
    for (int n = 0; n < 10 && req_en !== 1'b1; n++) step();
    check("pr3_req_en", 32'(req_en), 32'd1);
    check("pr3_req_tag", 32'(req_tag), 32'b1011);
    check("pr_pending", 32'(pending), 32'b01);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    step();
    rsp_expect("post_rst0", 4'b1000, 1'b0, 11'h000, 1'b0);
    rsp_expect("post_rst1", 4'b0001, 1'b0, 11'h000, 1'b0);
    rsp_expect("post_rst2", 4'b1010, 1'b0, 11'h000, 1'b0);
    check("post_rst_pending", 32'(pending), 32'd0);
    check("post_rst_req_en", 32'(req_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
